// File: rtl/vram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_access_arbiter
// Description : Single-port VRAM arbiter. Display reads have absolute
//               priority; physics (read/write, lockable) normally beats
//               cursor draw writes unless the draw has waited too long.
//               Read returns are routed back through a tag shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_access_arbiter #(
  parameter int unsigned VRAM_ADDR_WIDTH = 19,
  parameter int unsigned VRAM_DATA_WIDTH = 1,
  parameter int unsigned ACTIVE_COLUMNS  = 640,
  parameter int unsigned ACTIVE_ROWS     = 480,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned DRAW_MAX_WAIT   = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       disp_req_i,
  input  logic [VRAM_ADDR_WIDTH-1:0] disp_addr_i,
  output logic [VRAM_DATA_WIDTH-1:0] disp_rdata_o,
  output logic                       disp_rvalid_o,
  input  logic                       phy_req_i,
  input  logic                       phy_we_i,
  input  logic                       phy_lock_i,
  input  logic [VRAM_ADDR_WIDTH-1:0] phy_addr_i,
  input  logic [VRAM_DATA_WIDTH-1:0] phy_wdata_i,
  output logic                       phy_gnt_o,
  output logic [VRAM_DATA_WIDTH-1:0] phy_rdata_o,
  output logic                       phy_rvalid_o,
  input  logic                       drw_req_i,
  input  logic [VRAM_ADDR_WIDTH-1:0] drw_addr_i,
  input  logic [VRAM_DATA_WIDTH-1:0] drw_wdata_i,
  output logic                       drw_gnt_o,
  output logic                       vram_en_o,
  output logic                       vram_we_o,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_addr_o,
  output logic [VRAM_DATA_WIDTH-1:0] vram_wdata_o,
  input  logic [VRAM_DATA_WIDTH-1:0] vram_rdata_i,
  output logic                       oor_err_o
);

  localparam int unsigned C_ADDR_LIMIT_INT = ACTIVE_COLUMNS * ACTIVE_ROWS;
  localparam logic [VRAM_ADDR_WIDTH-1:0] C_ADDR_LIMIT = C_ADDR_LIMIT_INT[VRAM_ADDR_WIDTH-1:0];
  localparam logic [7:0] C_WAIT_MAX = DRAW_MAX_WAIT[7:0];

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [7:0] drw_wait_q;
  logic       oor_err_q;
  logic       phy_oor, drw_oor, draw_urgent;
  logic       disp_issue, phy_issue, zero_issue;
  logic [RD_LATENCY-1:0] disp_pipe, phy_pipe, zero_pipe;

  assign phy_oor = (phy_addr_i >= C_ADDR_LIMIT);
  assign drw_oor = (drw_addr_i >= C_ADDR_LIMIT);
  // A starved draw only outranks physics while no read-modify-write lock is held
  assign draw_urgent = (drw_wait_q == C_WAIT_MAX) && (state_q == ST_OPEN);

  // Lock state register; reset drops any held lock
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_OPEN;
    else           state_q <= state_d;
  end

  // Grant decision, next lock state and VRAM command mux
  always_comb begin
    state_d      = state_q;
    phy_gnt_o    = 1'b0;
    drw_gnt_o    = 1'b0;
    vram_en_o    = 1'b0;
    vram_we_o    = 1'b0;
    vram_addr_o  = '0;
    vram_wdata_o = '0;
    disp_issue   = 1'b0;
    phy_issue    = 1'b0;
    zero_issue   = 1'b0;
    if (reset_ni) begin
      if (disp_req_i) begin
        vram_en_o   = 1'b1;
        vram_addr_o = disp_addr_i;
        disp_issue  = 1'b1;
      end else if (phy_req_i && !(drw_req_i && draw_urgent)) begin
        phy_gnt_o    = 1'b1;
        vram_en_o    = !phy_oor;
        vram_we_o    = phy_we_i && !phy_oor;
        vram_addr_o  = phy_addr_i;
        vram_wdata_o = phy_we_i ? phy_wdata_i : '0;
        phy_issue    = !phy_we_i;
        zero_issue   = !phy_we_i && phy_oor;
        state_d      = phy_lock_i ? ST_LOCKED : ST_OPEN;
      end else if (drw_req_i && (state_q == ST_OPEN)) begin
        drw_gnt_o    = 1'b1;
        vram_en_o    = !drw_oor;
        vram_we_o    = !drw_oor;
        vram_addr_o  = drw_addr_i;
        vram_wdata_o = drw_wdata_i;
      end
    end
  end

  // Draw starvation counter and sticky out-of-range flag
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      drw_wait_q <= '0;
      oor_err_q  <= 1'b0;
    end else begin
      if (drw_gnt_o)                              drw_wait_q <= '0;
      else if (drw_req_i && drw_wait_q < C_WAIT_MAX) drw_wait_q <= drw_wait_q + 8'd1;
      if ((phy_gnt_o && phy_oor) || (drw_gnt_o && drw_oor)) oor_err_q <= 1'b1;
    end
  end

  generate
    if (RD_LATENCY == 1) begin : g_pipe_single
      // Single-stage read tag register
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          disp_pipe <= '0;
          phy_pipe  <= '0;
          zero_pipe <= '0;
        end else begin
          disp_pipe <= disp_issue;
          phy_pipe  <= phy_issue;
          zero_pipe <= zero_issue;
        end
      end
    end else begin : g_pipe_multi
      // Multi-stage read tag shift register
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          disp_pipe <= '0;
          phy_pipe  <= '0;
          zero_pipe <= '0;
        end else begin
          disp_pipe <= {disp_pipe[RD_LATENCY-2:0], disp_issue};
          phy_pipe  <= {phy_pipe[RD_LATENCY-2:0], phy_issue};
          zero_pipe <= {zero_pipe[RD_LATENCY-2:0], zero_issue};
        end
      end
    end
  endgenerate

  // Out-of-range physics reads return zero instead of whatever the VRAM bus holds
  assign disp_rvalid_o = disp_pipe[RD_LATENCY-1];
  assign phy_rvalid_o  = phy_pipe[RD_LATENCY-1];
  assign disp_rdata_o  = disp_rvalid_o ? vram_rdata_i : '0;
  assign phy_rdata_o   = (phy_rvalid_o && !zero_pipe[RD_LATENCY-1]) ? vram_rdata_i : '0;
  assign oor_err_o     = oor_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_access_arbiter
// Description : Directed self-checking bench for vram_access_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_access_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        disp_req_i = 1'b0;
  logic [18:0] disp_addr_i = '0;
  logic        disp_rdata_o, disp_rvalid_o;
  logic        phy_req_i = 1'b0, phy_we_i = 1'b0, phy_lock_i = 1'b0;
  logic [18:0] phy_addr_i = '0;
  logic        phy_wdata_i = 1'b0;
  logic        phy_gnt_o, phy_rdata_o, phy_rvalid_o;
  logic        drw_req_i = 1'b0;
  logic [18:0] drw_addr_i = '0;
  logic        drw_wdata_i = 1'b0;
  logic        drw_gnt_o;
  logic        vram_en_o, vram_we_o;
  logic [18:0] vram_addr_o;
  logic        vram_wdata_o;
  logic        vram_rdata_i;
  logic        oor_err_o;

  int tests = 0;
  int fails = 0;

  vram_access_arbiter #(
    .VRAM_ADDR_WIDTH(19), .VRAM_DATA_WIDTH(1), .ACTIVE_COLUMNS(640),
    .ACTIVE_ROWS(480), .RD_LATENCY(2), .DRAW_MAX_WAIT(16)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
    .disp_rdata_o(disp_rdata_o), .disp_rvalid_o(disp_rvalid_o),
    .phy_req_i(phy_req_i), .phy_we_i(phy_we_i), .phy_lock_i(phy_lock_i),
    .phy_addr_i(phy_addr_i), .phy_wdata_i(phy_wdata_i), .phy_gnt_o(phy_gnt_o),
    .phy_rdata_o(phy_rdata_o), .phy_rvalid_o(phy_rvalid_o),
    .drw_req_i(drw_req_i), .drw_addr_i(drw_addr_i), .drw_wdata_i(drw_wdata_i),
    .drw_gnt_o(drw_gnt_o),
    .vram_en_o(vram_en_o), .vram_we_o(vram_we_o), .vram_addr_o(vram_addr_o),
    .vram_wdata_o(vram_wdata_o), .vram_rdata_i(vram_rdata_i),
    .oor_err_o(oor_err_o)
  );

  always #5 clk_i = ~clk_i;

  // VRAM model: two-cycle read latency, word value = address bit 1, idle bus reads 1
  logic s1 = 1'b1, s2 = 1'b1;
  always @(posedge clk_i) begin
    s1 <= (vram_en_o && !vram_we_o) ? vram_addr_o[1] : 1'b1;
    s2 <= s1;
  end
  assign vram_rdata_i = s2;

  typedef struct {
    logic        dr; logic [18:0] da;
    logic        pr; logic pw; logic pl; logic [18:0] pa; logic pd;
    logic        wr; logic [18:0] wa; logic wd;
    logic [23:0] exp;   // {phy_gnt, drw_gnt, en, we, addr, wdata}
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic dr, input logic [18:0] da,
                        input logic pr, input logic pw, input logic pl,
                        input logic [18:0] pa, input logic pd,
                        input logic wr, input logic [18:0] wa, input logic wd);
    disp_req_i = dr; disp_addr_i = da;
    phy_req_i = pr; phy_we_i = pw; phy_lock_i = pl; phy_addr_i = pa; phy_wdata_i = pd;
    drw_req_i = wr; drw_addr_i = wa; drw_wdata_i = wd;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Move to the next cycle: past the active edge, then to the sampling point
  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  function automatic logic [23:0] cmd();
    return {phy_gnt_o, drw_gnt_o, vram_en_o, vram_we_o, vram_addr_o, vram_wdata_o};
  endfunction

  function automatic logic [23:0] mk(input logic pg, input logic dg, input logic en,
                                     input logic we, input logic [18:0] a, input logic wd);
    return {pg, dg, en, we, a, wd};
  endfunction

  vec_t vecs[9];

  initial begin
    // dr  da   pr pw pl pa      pd  wr wa   wd  expected
    vecs[0] = '{1, 10, 1, 0, 0, 20,     0, 1, 30, 1, mk(0, 0, 1, 0, 10, 0)};
    vecs[1] = '{0, 0,  1, 0, 0, 20,     0, 1, 30, 1, mk(1, 0, 1, 0, 20, 0)};
    vecs[2] = '{0, 0,  0, 0, 0, 0,      0, 1, 30, 1, mk(0, 1, 1, 1, 30, 1)};
    vecs[3] = '{0, 0,  1, 1, 0, 40,     1, 0, 0,  0, mk(1, 0, 1, 1, 40, 1)};
    vecs[4] = '{0, 0,  0, 0, 0, 0,      0, 0, 0,  0, mk(0, 0, 0, 0, 0, 0)};
    vecs[5] = '{1, 7,  0, 0, 0, 0,      0, 0, 0,  0, mk(0, 0, 1, 0, 7, 0)};
    vecs[6] = '{0, 0,  1, 0, 0, 307199, 0, 0, 0,  0, mk(1, 0, 1, 0, 307199, 0)};
    vecs[7] = '{1, 12, 0, 0, 0, 0,      0, 1, 13, 0, mk(0, 0, 1, 0, 12, 0)};
    vecs[8] = '{0, 0,  0, 0, 0, 0,      0, 1, 13, 0, mk(0, 1, 1, 1, 13, 0)};

    // Reset state: every requester active, nothing may be granted or issued
    set_in(1, 3, 1, 0, 0, 4, 0, 1, 5, 1);
    @(negedge clk_i);
    check("reset_cmd", {8'd0, cmd()}, 32'd0);
    check("reset_rv", {30'd0, disp_rvalid_o, phy_rvalid_o}, 32'd0);
    check("reset_oor", {31'd0, oor_err_o}, 32'd0);
    idle();
    @(posedge clk_i); #1 reset_ni = 1'b1;
    next_cycle();

    // Table-driven single-cycle arbitration vectors
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].dr, vecs[i].da, vecs[i].pr, vecs[i].pw, vecs[i].pl,
             vecs[i].pa, vecs[i].pd, vecs[i].wr, vecs[i].wa, vecs[i].wd);
      @(negedge clk_i);
      check($sformatf("vec%0d", i), {8'd0, cmd()}, {8'd0, vecs[i].exp});
      next_cycle();
    end
    idle();
    next_cycle();

    // Starvation: physics read held continuously, draw wins in its 17th cycle
    set_in(0, 0, 1, 0, 0, 50, 0, 1, 100, 1);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk_i);
      if (k < 17) check($sformatf("starve_c%0d", k), {30'd0, phy_gnt_o, drw_gnt_o}, 32'b10);
      else        check("starve_win", {8'd0, cmd()}, {8'd0, mk(0, 1, 1, 1, 100, 1)});
      next_cycle();
    end
    set_in(0, 0, 1, 0, 0, 50, 0, 0, 0, 0);
    @(negedge clk_i);
    check("starve_resume", {8'd0, cmd()}, {8'd0, mk(1, 0, 1, 0, 50, 0)});
    next_cycle();
    set_in(0, 0, 1, 0, 0, 50, 0, 1, 101, 1);
    @(negedge clk_i);
    check("starve_cleared", {30'd0, phy_gnt_o, drw_gnt_o}, 32'b10);
    next_cycle();

    // Lock: draw blocked through saturation until the unlocking physics write
    set_in(0, 0, 1, 0, 1, 640, 0, 1, 200, 1);
    @(negedge clk_i);
    check("lock_take", {30'd0, phy_gnt_o, drw_gnt_o}, 32'b10);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 200, 1);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk_i);
      if (drw_gnt_o !== 1'b0) check("lock_hold", {31'd0, drw_gnt_o}, 32'd0);
      next_cycle();
    end
    check("lock_hold_all", {31'd0, drw_gnt_o}, 32'd0);
    set_in(0, 0, 1, 1, 0, 640, 1, 1, 200, 1);
    @(negedge clk_i);
    check("lock_release", {8'd0, cmd()}, {8'd0, mk(1, 0, 1, 1, 640, 1)});
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 200, 1);
    @(negedge clk_i);
    check("lock_draw_after", {8'd0, cmd()}, {8'd0, mk(0, 1, 1, 1, 200, 1)});
    next_cycle();
    idle();
    next_cycle(); next_cycle(); next_cycle();

    // Read return ordering with two-cycle latency
    set_in(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    set_in(0, 0, 1, 0, 0, 6, 0, 0, 0, 0);
    @(negedge clk_i);
    check("rd_n1_rv", {30'd0, disp_rvalid_o, phy_rvalid_o}, 32'b00);
    next_cycle();
    idle();
    @(negedge clk_i);
    check("rd_n2", {29'd0, disp_rvalid_o, phy_rvalid_o, disp_rdata_o}, 32'b100);
    next_cycle();
    @(negedge clk_i);
    check("rd_n3", {29'd0, disp_rvalid_o, phy_rvalid_o, phy_rdata_o}, 32'b011);
    next_cycle();
    @(negedge clk_i);
    check("rd_n4", {30'd0, disp_rvalid_o, phy_rvalid_o}, 32'b00);

    // Out of range: draw write consumed without access, sticky error
    check("oor_before", {31'd0, oor_err_o}, 32'd0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 307200, 1);
    @(negedge clk_i);
    check("oor_drw_cmd", {29'd0, drw_gnt_o, vram_en_o, vram_we_o}, 32'b100);
    check("oor_same_cycle", {31'd0, oor_err_o}, 32'd0);
    next_cycle();
    idle();
    @(negedge clk_i);
    check("oor_set", {31'd0, oor_err_o}, 32'd1);
    next_cycle();
    set_in(0, 0, 1, 0, 0, 307200, 0, 0, 0, 0);
    @(negedge clk_i);
    check("oor_phy_cmd", {30'd0, phy_gnt_o, vram_en_o}, 32'b10);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk_i);
    check("oor_phy_ret", {30'd0, phy_rvalid_o, phy_rdata_o}, 32'b10);
    check("oor_sticky", {31'd0, oor_err_o}, 32'd1);
    next_cycle();

    // Reset mid-operation with a locked physics read in flight
    set_in(0, 0, 1, 0, 1, 8, 0, 0, 0, 0);
    @(negedge clk_i);
    check("mid_issue", {31'd0, phy_gnt_o}, 32'd1);
    next_cycle();
    set_in(1, 9, 1, 0, 0, 9, 0, 1, 9, 1);
    reset_ni = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check($sformatf("mid_rst_c%0d", k),
            {6'd0, disp_rvalid_o, phy_rvalid_o, cmd()}, 32'd0);
      next_cycle();
    end
    check("mid_rst_oor", {31'd0, oor_err_o}, 32'd0);
    idle();
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("mid_rst_norv", {30'd0, disp_rvalid_o, phy_rvalid_o}, 32'd0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 77, 1);
    @(negedge clk_i);
    check("mid_unlocked", {8'd0, cmd()}, {8'd0, mk(0, 1, 1, 1, 77, 1)});
    next_cycle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
